present_sbox_serializer: RTL

Round-datapath sequencer that sits directly upstream and downstream of the three-share, second-order masked PRESENT S-box. It holds the three 64-bit Boolean shares of the cipher state and streams one nibble per share per cycle into the pipelined S-box. It gathers the S-box outputs back into the state after the pipeline latency, then applies the PRESENT pLayer to each share independently. It covers one sBoxLayer plus pLayer per start; key addition and round counting live in the enclosing controller.

---
 rtl/present_sbox_serializer.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/present_sbox_serializer.sv
// Share-preserving nibble sequencer around a pipelined three-share PRESENT S-box:
// streams the 16 nibbles out, gathers the delayed results back, then applies pLayer per share.
module present_sbox_serializer #(
   parameter int SBOX_LAT = 4
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_load,
   input  logic        i_start,
   input  logic [63:0] i_state_in1,
   input  logic [63:0] i_state_in2,
   input  logic [63:0] i_state_in3,
   output logic [3:0]  o_sbox_in1,
   output logic [3:0]  o_sbox_in2,
   output logic [3:0]  o_sbox_in3,
   input  logic [3:0]  i_sbox_out1,
   input  logic [3:0]  i_sbox_out2,
   input  logic [3:0]  i_sbox_out3,
   output logic        o_rnd_req,
   output logic [63:0] o_state_out1,
   output logic [63:0] o_state_out2,
   output logic [63:0] o_state_out3,
   output logic        o_busy,
   output logic        o_done
);

   localparam int               CNT_W        = $clog2(16 + SBOX_LAT);
   localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(15 + SBOX_LAT);
   localparam logic [CNT_W-1:0] CNT_FEED_END = CNT_W'(16);
   localparam logic [CNT_W-1:0] CNT_LAT      = CNT_W'(SBOX_LAT);

   typedef enum logic [1:0] {
      S_IDLE,
      S_FEED,
      S_PLAYER
   } state_t;

   state_t           r_state;
   state_t           w_state_next;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_next;
   logic             r_done;
   logic             w_done_next;

   logic [2:0][63:0] w_state_in;
   logic [2:0][63:0] w_share;
   logic [2:0][3:0]  w_sbox_in;
   logic [2:0][3:0]  w_sbox_out;

   logic             w_feeding;
   logic             w_capture;
   logic             w_load_en;
   logic             w_player_en;
   logic [3:0]       w_rd_idx;
   logic [3:0]       w_wr_idx;

   assign w_state_in = {i_state_in3, i_state_in2, i_state_in1};
   assign w_sbox_out = {i_sbox_out3, i_sbox_out2, i_sbox_out1};

   // Feeding and capturing overlap: capture trails the feed index by the pipeline depth.
   assign w_feeding   = (r_state == S_FEED) && (r_cnt < CNT_FEED_END);
   assign w_capture   = (r_state == S_FEED) && (r_cnt >= CNT_LAT);
   assign w_load_en   = (r_state == S_IDLE) && i_load;
   assign w_player_en = (r_state == S_PLAYER);
   assign w_rd_idx    = r_cnt[3:0];
   assign w_wr_idx    = 4'(r_cnt - CNT_LAT);

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
         r_done  <= w_done_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_done_next  = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (i_start) begin
               w_state_next = S_FEED;
               w_cnt_next   = '0;
            end
         end
         S_FEED: begin
            if (r_cnt == CNT_LAST) begin
               w_state_next = S_PLAYER;
               w_cnt_next   = '0;
            end else begin
               w_cnt_next = r_cnt + CNT_W'(1);
            end
         end
         S_PLAYER: begin
            w_state_next = S_IDLE;
            w_done_next  = 1'b1;
         end
         default: begin
            w_state_next = S_IDLE;
            w_cnt_next   = '0;
         end
      endcase
   end

   // Each share owns its own registers and permutation; nothing crosses share indices.
   for (genvar gi = 0; gi < 3; gi++) begin : g_share
      logic [63:0] r_share;
      logic [63:0] r_result;
      logic [63:0] w_player;

      always_ff @(posedge i_clk) begin
         if (!i_rst_n) begin
            r_share  <= '0;
            r_result <= '0;
         end else begin
            if (w_player_en) begin
               r_share <= w_player;
            end else if (w_load_en) begin
               r_share <= w_state_in[gi];
            end
            if (w_capture) begin
               r_result[{w_wr_idx, 2'b00} +: 4] <= w_sbox_out[gi];
            end
         end
      end

      // pLayer: bit j moves to 16*j mod 63; bit 63 is a fixed point.
      for (genvar gj = 0; gj < 64; gj++) begin : g_bit
         localparam int DST = (gj == 63) ? 63 : ((16 * gj) % 63);
         assign w_player[DST] = r_result[gj];
      end

      assign w_share[gi]   = r_share;
      assign w_sbox_in[gi] = w_feeding ? r_share[{w_rd_idx, 2'b00} +: 4] : 4'h0;
   end

   assign o_sbox_in1   = w_sbox_in[0];
   assign o_sbox_in2   = w_sbox_in[1];
   assign o_sbox_in3   = w_sbox_in[2];
   assign o_state_out1 = w_share[0];
   assign o_state_out2 = w_share[1];
   assign o_state_out3 = w_share[2];
   assign o_rnd_req    = w_feeding;
   assign o_busy       = (r_state != S_IDLE);
   assign o_done       = r_done;

endmodule
